riscv_accel_wb: RTL and testbench

//  Parametrised write-back sequencer for wide accelerator results (AES and later engines).
//  - Captures an N-word result and a base address on a start pulse.
//  - Replays the result as consecutive single-word writes onto the core data-memory write port.
//  - Holds the pipeline halt request for the whole transfer.
//  - Pacing is either a fixed inter-write gap or a grant handshake.
//  - Signals completion with a one-cycle done pulse.

---
 rtl/riscv_accel_wb.sv | 164 ++++++++++++++++
 tb/tb_riscv_accel_wb.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/riscv_accel_wb.sv
// Write-back sequencer: captures a multi-word accelerator result and replays it
// as single-word stores on the data-memory write port while holding the pipeline.
module riscv_accel_wb #(
    parameter int WORD_W      = 32,
    parameter int NUM_WORDS   = 4,
    parameter int ADDR_W      = 32,
    parameter int ADDR_STRIDE = 4,
    parameter int GAP_CYCLES  = 5,
    parameter int USE_GNT     = 0,
    parameter int BIG_ENDIAN  = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_wb,
    input  logic [$clog2(NUM_WORDS+1)-1:0] len_in,
    input  logic [ADDR_W-1:0]             address_in,
    input  logic [WORD_W*NUM_WORDS-1:0]   data_in,
    input  logic                          wr_gnt_in,
    output logic                          write_en_out,
    output logic [ADDR_W-1:0]             address_out,
    output logic [WORD_W-1:0]             data_out,
    output logic                          halt_en_out,
    output logic                          busy_out,
    output logic                          done_out
);

    localparam int DATA_W = WORD_W * NUM_WORDS;
    localparam int LEN_W  = $clog2(NUM_WORDS + 1);
    localparam int GAP_W  = $clog2(GAP_CYCLES + 2);

    typedef enum logic [1:0] {IDLE, ISSUE, GAP, DONE} state_t;

    state_t              state_q, state_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [ADDR_W-1:0]   addr_out_q, addr_out_d;
    logic [WORD_W-1:0]   wdata_q, wdata_d;
    logic [LEN_W-1:0]    len_clamped;
    logic [LEN_W-1:0]    cnt_inc;
    logic                accept;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        return (len > LEN_W'(NUM_WORDS)) ? LEN_W'(NUM_WORDS) : len;
    endfunction

    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [LEN_W-1:0]  cnt);
        // Truncation to ADDR_W gives the intended silent wrap-around.
        return base + ADDR_W'(cnt) * ADDR_W'(ADDR_STRIDE);
    endfunction

    function automatic logic [WORD_W-1:0] pick_word(input logic [DATA_W-1:0] d,
                                                    input logic [LEN_W-1:0]  len,
                                                    input logic [LEN_W-1:0]  cnt);
        logic [LEN_W-1:0]  idx;
        logic [WORD_W-1:0] w;
        idx = (BIG_ENDIAN != 0) ? (len - LEN_W'(1) - cnt) : cnt;
        w   = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            if (idx == LEN_W'(i)) begin
                w = d[i*WORD_W +: WORD_W];
            end
        end
        return w;
    endfunction

    assign len_clamped = clamp_len(len_in);
    assign cnt_inc     = cnt_q + LEN_W'(1);
    assign accept      = (USE_GNT == 0) || wr_gnt_in;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        gap_d      = gap_q;
        base_d     = base_q;
        data_d     = data_q;
        addr_out_d = addr_out_q;
        wdata_d    = wdata_q;
        unique case (state_q)
            IDLE: begin
                if (start_wb) begin
                    data_d = data_in;
                    base_d = address_in;
                    len_d  = len_clamped;
                    cnt_d  = '0;
                    if (len_clamped == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d    = ISSUE;
                        addr_out_d = address_in;
                        wdata_d    = pick_word(data_in, len_clamped, '0);
                    end
                end
            end
            ISSUE: begin
                if (accept) begin
                    cnt_d = cnt_inc;
                    if (GAP_CYCLES > 0) begin
                        state_d = GAP;
                        gap_d   = '0;
                    end else if (cnt_inc == len_q) begin
                        state_d = DONE;
                    end else begin
                        addr_out_d = word_addr(base_q, cnt_inc);
                        wdata_d    = pick_word(data_q, len_q, cnt_inc);
                    end
                end
            end
            GAP: begin
                if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                    if (cnt_q < len_q) begin
                        state_d    = ISSUE;
                        addr_out_d = word_addr(base_q, cnt_q);
                        wdata_d    = pick_word(data_q, len_q, cnt_q);
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            gap_q      <= '0;
            base_q     <= '0;
            data_q     <= '0;
            addr_out_q <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            gap_q      <= gap_d;
            base_q     <= base_d;
            data_q     <= data_d;
            addr_out_q <= addr_out_d;
            wdata_q    <= wdata_d;
        end
    end

    assign write_en_out = (state_q == ISSUE);
    assign halt_en_out  = (state_q != IDLE);
    assign busy_out     = (state_q != IDLE);
    assign done_out     = (state_q == DONE);
    assign address_out  = addr_out_q;
    assign data_out     = wdata_q;

endmodule

// File: tb/tb_riscv_accel_wb.sv
// Directed bench for riscv_accel_wb: three instances cover timed, big-endian
// back-to-back and grant-paced configurations.
module tb_riscv_accel_wb;

    logic         clk;
    logic         rst;
    logic         st [3];
    logic [2:0]   len_i;
    logic [31:0]  addr_i;
    logic [127:0] data_i;
    logic         gnt;
    logic         we_o   [3];
    logic [31:0]  ao     [3];
    logic [31:0]  do_    [3];
    logic         halt_o [3];
    logic         busy_o [3];
    logic         done_o [3];

    int checks = 0;
    int errors = 0;
    int sel    = 0;

    typedef struct {
        int              sel;
        logic [2:0]      len;
        logic [31:0]     addr;
        logic [127:0]    data;
        int              n_exp;
        logic [3:0][31:0] ea;
        logic [3:0][31:0] ed;
        int              period;
        int              done_cyc;
        int              wait_n;
    } vec_t;

    vec_t vecs [10];

    localparam logic [127:0] D1 = 128'h00000044_00000033_00000022_00000011;
    localparam logic [127:0] D2 = 128'hD3D3D3D3_C2C2C2C2_B1B1B1B1_A0A0A0A0;

    riscv_accel_wb u_def (
        .clk(clk), .rst(rst), .start_wb(st[0]), .len_in(len_i), .address_in(addr_i),
        .data_in(data_i), .wr_gnt_in(gnt), .write_en_out(we_o[0]), .address_out(ao[0]),
        .data_out(do_[0]), .halt_en_out(halt_o[0]), .busy_out(busy_o[0]), .done_out(done_o[0])
    );

    riscv_accel_wb #(.GAP_CYCLES(0), .BIG_ENDIAN(1)) u_be (
        .clk(clk), .rst(rst), .start_wb(st[1]), .len_in(len_i), .address_in(addr_i),
        .data_in(data_i), .wr_gnt_in(gnt), .write_en_out(we_o[1]), .address_out(ao[1]),
        .data_out(do_[1]), .halt_en_out(halt_o[1]), .busy_out(busy_o[1]), .done_out(done_o[1])
    );

    riscv_accel_wb #(.GAP_CYCLES(0), .USE_GNT(1)) u_gnt (
        .clk(clk), .rst(rst), .start_wb(st[2]), .len_in(len_i), .address_in(addr_i),
        .data_in(data_i), .wr_gnt_in(gnt), .write_en_out(we_o[2]), .address_out(ao[2]),
        .data_out(do_[2]), .halt_en_out(halt_o[2]), .busy_out(busy_o[2]), .done_out(done_o[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input int s, input int len, input logic [31:0] addr,
                                input logic [127:0] data, input int n,
                                input logic [127:0] ea, input logic [127:0] ed,
                                input int per, input int dn, input int w);
        vec_t v;
        v.sel = s; v.len = 3'(len); v.addr = addr; v.data = data; v.n_exp = n;
        v.ea = ea; v.ed = ed; v.period = per; v.done_cyc = dn; v.wait_n = w;
        return v;
    endfunction

    task automatic run_vec(input int k);
        vec_t v;
        int   cyc, nw, hold;
        bit   got_done;
        v = vecs[k];
        sel = v.sel;
        len_i = v.len; addr_i = v.addr; data_i = v.data; gnt = 1'b0;
        st[sel] = 1'b1;
        step();
        st[sel] = 1'b0;
        // Captured copies must be used from here on.
        addr_i = $urandom; data_i = {$urandom, $urandom, $urandom, $urandom}; len_i = 3'($urandom);
        cyc = 1; nw = 0; hold = 0; got_done = 0;
        while (!got_done && cyc < 200) begin
            st[sel] = 1'b0;
            chk($sformatf("v%0d_halt_c%0d", k, cyc), 32'(halt_o[sel]), 32'd1);
            if (we_o[sel]) begin
                if (nw >= 4) begin
                    chk($sformatf("v%0d_extra_write", k), nw, v.n_exp);
                end else if (hold == 0) begin
                    chk($sformatf("v%0d_wcyc%0d", k, nw), cyc, 1 + v.period * nw);
                    chk($sformatf("v%0d_addr%0d", k, nw), ao[sel], v.ea[nw]);
                    chk($sformatf("v%0d_data%0d", k, nw), do_[sel], v.ed[nw]);
                end
                hold++;
                if (v.sel == 2) begin
                    if (hold == v.wait_n + 1) begin
                        if (nw < 4) begin
                            chk($sformatf("v%0d_stable_addr%0d", k, nw), ao[sel], v.ea[nw]);
                            chk($sformatf("v%0d_stable_data%0d", k, nw), do_[sel], v.ed[nw]);
                        end
                        gnt = 1'b1; nw++; hold = 0;
                    end else begin
                        gnt = 1'b0;
                    end
                end else begin
                    nw++; hold = 0;
                end
            end else begin
                gnt = 1'b0;
            end
            if (done_o[sel]) begin
                got_done = 1;
                chk($sformatf("v%0d_done_cycle", k), cyc, v.done_cyc);
            end else begin
                if (cyc == 2) st[sel] = 1'b1;
                step();
                cyc++;
            end
        end
        chk($sformatf("v%0d_done_seen", k), 32'(got_done), 32'd1);
        chk($sformatf("v%0d_nwrites", k), nw, v.n_exp);
        gnt = 1'b0;
        st[sel] = 1'b1;
        step();
        chk($sformatf("v%0d_halt_after_done", k), 32'(halt_o[sel]), 32'd0);
        chk($sformatf("v%0d_we_after_done", k), 32'(we_o[sel]), 32'd0);
        chk($sformatf("v%0d_done_pulse", k), 32'(done_o[sel]), 32'd0);
        if (v.n_exp > 0) begin
            chk($sformatf("v%0d_addr_hold", k), ao[sel], v.ea[v.n_exp-1]);
            chk($sformatf("v%0d_data_hold", k), do_[sel], v.ed[v.n_exp-1]);
        end
        st[sel] = 1'b0;
        step();
        chk($sformatf("v%0d_start_in_done_dropped", k), 32'(busy_o[sel]), 32'd0);
    endtask

    initial begin
        int nwe;
        rst = 1'b1; gnt = 1'b0; len_i = '0; addr_i = '0; data_i = '0;
        for (int i = 0; i < 3; i++) st[i] = 1'b0;

        vecs[0] = mk(0, 4, 32'h1000, D1, 4, {32'h100C, 32'h1008, 32'h1004, 32'h1000}, D1, 6, 25, 0);
        vecs[1] = mk(0, 0, 32'h2000, D1, 0, '0, '0, 6, 1, 0);
        vecs[2] = mk(0, 7, 32'h3000, D2, 4, {32'h300C, 32'h3008, 32'h3004, 32'h3000}, D2, 6, 25, 0);
        vecs[3] = mk(0, 4, 32'hFFFF_FFF8, D1, 4, {32'h4, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFF8}, D1, 6, 25, 0);
        vecs[4] = mk(0, 1, 32'h10, D2, 1, {96'h0, 32'h10}, {96'h0, 32'hA0A0A0A0}, 6, 7, 0);
        vecs[5] = mk(1, 2, 32'h20, D2, 2, {64'h0, 32'h24, 32'h20}, {64'h0, 32'hA0A0A0A0, 32'hB1B1B1B1}, 1, 3, 0);
        vecs[6] = mk(1, 4, 32'h100, D1, 4, {32'h10C, 32'h108, 32'h104, 32'h100},
                     {32'h11, 32'h22, 32'h33, 32'h44}, 1, 5, 0);
        vecs[7] = mk(2, 2, 32'h40, D1, 2, {64'h0, 32'h44, 32'h40}, {64'h0, 32'h22, 32'h11}, 4, 9, 3);
        vecs[8] = mk(2, 3, 32'h80, D2, 3, {32'h0, 32'h88, 32'h84, 32'h80},
                     {32'h0, 32'hC2C2C2C2, 32'hB1B1B1B1, 32'hA0A0A0A0}, 1, 4, 0);
        vecs[9] = mk(1, 0, 32'h50, D1, 0, '0, '0, 1, 1, 0);

        repeat (3) step();
        chk("rst_we", 32'(we_o[0]), 32'd0);
        chk("rst_addr", ao[0], 32'd0);
        chk("rst_data", do_[0], 32'd0);
        chk("rst_done", 32'(done_o[0]), 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_halt%0d", i), 32'(halt_o[i]), 32'd0);
            chk($sformatf("rst_busy%0d", i), 32'(busy_o[i]), 32'd0);
        end
        rst = 1'b0;
        step();

        for (int k = 0; k < 10; k++) run_vec(k);

        // Reset during the second gap aborts the transfer outright.
        sel = 0;
        len_i = 3'd4; addr_i = 32'h1000; data_i = D1;
        st[0] = 1'b1;
        step();
        st[0] = 1'b0;
        repeat (8) step();
        chk("gap2_we", 32'(we_o[0]), 32'd0);
        chk("gap2_halt", 32'(halt_o[0]), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_we", 32'(we_o[0]), 32'd0);
        chk("midrst_addr", ao[0], 32'd0);
        chk("midrst_data", do_[0], 32'd0);
        chk("midrst_halt", 32'(halt_o[0]), 32'd0);
        chk("midrst_busy", 32'(busy_o[0]), 32'd0);
        chk("midrst_done", 32'(done_o[0]), 32'd0);
        nwe = 0;
        repeat (10) begin
            step();
            if (we_o[0] || busy_o[0]) nwe++;
        end
        chk("no_activity_after_rst", nwe, 0);
        run_vec(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
